// File: rtl/fp_unit_arbiter_if.sv
// Requester-side and FP-unit-side signals of the shared FP unit arbiter.
// The slave modport is the arbiter; master is whoever drives requests and models the unit.
interface fp_unit_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [32*NUM_REQ-1:0] req_dataa;
   logic [32*NUM_REQ-1:0] req_datab;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [31:0]           resp_result;
   logic                  resp_timeout;
   logic                  busy;
   logic                  unit_enable;
   logic [31:0]           unit_dataa;
   logic [31:0]           unit_datab;
   logic [31:0]           unit_result;
   logic                  unit_done;

   modport slave (
      input  req, req_dataa, req_datab, unit_result, unit_done,
      output resp_valid, resp_result, resp_timeout, busy,
             unit_enable, unit_dataa, unit_datab
   );

   modport master (
      output req, req_dataa, req_datab, unit_result, unit_done,
      input  resp_valid, resp_result, resp_timeout, busy,
             unit_enable, unit_dataa, unit_datab
   );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Round-robin time-sharing of one multi-cycle FP unit among NUM_REQ requesters.
// Latency: unit latency + 3 cycles; requesters hold req/operands until their resp_valid pulse.
module fp_unit_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT     = 64,
   parameter bit HOLD_ENABLE = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   fp_unit_arbiter_if.slave bus
);
   localparam int          IW   = $clog2(NUM_REQ);
   localparam int          CW   = $clog2(TIMEOUT) + 1;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_grant;
   logic [IW-1:0]   w_pick;
   logic            w_any;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_dataa;
   logic [31:0]     r_datab;
   logic [31:0]     r_result;
   logic            r_tmo;
   logic            w_timeout_hit;

   // A done arriving on the final WAIT cycle takes precedence over the abort.
   assign w_timeout_hit = (r_state == S_WAIT) && !bus.unit_done &&
                          (r_cnt == CW'(TIMEOUT - 1));

   // First requester at or after the pointer, wrapping.
   always_comb begin
      int idx;
      w_any  = 1'b0;
      w_pick = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(r_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_any && bus.req[IW'(idx)]) begin
            w_any  = 1'b1;
            w_pick = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next           = r_state;
      bus.unit_enable  = 1'b0;
      bus.resp_valid   = '0;
      bus.resp_timeout = 1'b0;
      bus.busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_any) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            bus.unit_enable = 1'b1;
            w_next          = bus.unit_done ? S_RESPOND : S_WAIT;
         end
         S_WAIT: begin
            bus.unit_enable = HOLD_ENABLE;
            if (bus.unit_done || w_timeout_hit) w_next = S_RESPOND;
         end
         S_RESPOND: begin
            bus.resp_valid[r_grant] = 1'b1;
            bus.resp_timeout        = r_tmo;
            w_next                  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr    <= '0;
         r_grant  <= '0;
         r_cnt    <= '0;
         r_dataa  <= '0;
         r_datab  <= '0;
         r_result <= '0;
         r_tmo    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_dataa <= bus.req_dataa[int'(w_pick)*32 +: 32];
                  r_datab <= bus.req_datab[int'(w_pick)*32 +: 32];
               end
            end
            S_ISSUE: begin
               r_cnt <= '0;
               if (bus.unit_done) r_result <= bus.unit_result;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               if (bus.unit_done) begin
                  r_result <= bus.unit_result;
               end else if (w_timeout_hit) begin
                  r_result <= QNAN;
                  r_tmo    <= 1'b1;
               end
            end
            S_RESPOND: begin
               r_ptr <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
               r_tmo <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // resp_result changes only on the edge into RESPOND, so it holds between responses.
   assign bus.resp_result = r_result;
   assign bus.unit_dataa  = r_dataa;
   assign bus.unit_datab  = r_datab;
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter; the bench plays both the requesters and the FP unit.
module tb_fp_unit_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   fp_unit_arbiter_if #(.NUM_REQ(NR)) bus ();
   fp_unit_arbiter_if #(.NUM_REQ(NR)) bus0 ();

   fp_unit_arbiter #(.NUM_REQ(NR), .TIMEOUT(64), .HOLD_ENABLE(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave)
   );
   fp_unit_arbiter #(.NUM_REQ(NR), .TIMEOUT(64), .HOLD_ENABLE(1'b0)) dut_pulse (
      .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.req_dataa[32*i +: 32] = a;
      bus.req_datab[32*i +: 32] = b;
   endtask

   task automatic pulse_reset;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick;
   endtask

   // Acts as the FP unit for one transaction: done is raised lat cycles after ISSUE.
   // Returns what the arbiter showed in RESPOND, edges from call to RESPOND, enable-high cycles.
   task automatic serve(input int lat, input logic [31:0] res_in,
                        output logic [3:0] vld, output logic [31:0] res, output logic tmo,
                        output logic [31:0] opa, output logic [31:0] opb,
                        output int cyc, output int en);
      cyc = 0;
      en  = 0;
      while (!bus.unit_enable && cyc < 50) begin
         tick;
         cyc++;
      end
      opa = bus.unit_dataa;
      opb = bus.unit_datab;
      en  = int'(bus.unit_enable);
      repeat (lat) begin
         tick;
         cyc++;
         en += int'(bus.unit_enable);
      end
      bus.unit_done   = 1'b1;
      bus.unit_result = res_in;
      tick;
      cyc++;
      bus.unit_done = 1'b0;
      vld = bus.resp_valid;
      res = bus.resp_result;
      tmo = bus.resp_timeout;
      en += int'(bus.unit_enable);
      bus.req = bus.req & ~bus.resp_valid;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.unit_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", bus.unit_enable); end
      checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL reset_vld: got %b want 0000", bus.resp_valid); end
      checks++; if (bus.resp_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.resp_result); end
      checks++; if (bus.resp_timeout !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", bus.resp_timeout); end
      checks++; if (bus.unit_dataa !== 32'h0 || bus.unit_datab !== 32'h0) begin
         errors++; $display("FAIL reset_operands: got %h/%h want 0/0", bus.unit_dataa, bus.unit_datab);
      end
      reset_n = 1'b1;
      tick;
   endtask

   task automatic test_single;
      logic [3:0] vld; logic [31:0] res, opa, opb; logic tmo; int cyc, en;
      set_ops(2, 32'h40400000, 32'h40000000);
      bus.req = 4'b0100;
      serve(5, 32'h40C00000, vld, res, tmo, opa, opb, cyc, en);
      checks++; if (vld !== 4'b0100) begin errors++; $display("FAIL single_vld: got %b want 0100", vld); end
      checks++; if (res !== 32'h40C00000) begin errors++; $display("FAIL single_result: got %h want 40c00000", res); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_tmo: got %b want 0", tmo); end
      checks++; if (opa !== 32'h40400000 || opb !== 32'h40000000) begin
         errors++; $display("FAIL single_operands: got %h/%h want 40400000/40000000", opa, opb);
      end
      // IDLE + ISSUE + 5 WAIT + RESPOND = 8 cycles, i.e. 7 edges to RESPOND.
      checks++; if (cyc !== 7) begin errors++; $display("FAIL single_latency: got %0d want 7", cyc); end
      checks++; if (en !== 6) begin errors++; $display("FAIL hold_enable_cycles: got %0d want 6", en); end
      tick;
      checks++; if (bus.resp_valid !== 4'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL single_after: vld=%b busy=%b want 0000/0", bus.resp_valid, bus.busy);
      end
   endtask

   task automatic test_all_four;
      logic [3:0] vld; logic [31:0] res, opa, opb; logic tmo; int cyc, en;
      logic [31:0] a [4]; logic [31:0] r [4]; int lat [4];
      lat = '{2, 1, 3, 0};
      pulse_reset;
      for (int k = 0; k < 4; k++) begin
         a[k] = 32'h41000000 | k;
         r[k] = 32'hC0000000 | (k << 4);
         set_ops(k, a[k], 32'h42000000 | k);
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         serve(lat[k], r[k], vld, res, tmo, opa, opb, cyc, en);
         checks++; if (vld !== 4'(1 << k)) begin errors++; $display("FAIL order_vld%0d: got %b want %b", k, vld, 4'(1 << k)); end
         checks++; if (opa !== a[k]) begin errors++; $display("FAIL order_opa%0d: got %h want %h", k, opa, a[k]); end
         checks++; if (res !== r[k]) begin errors++; $display("FAIL order_res%0d: got %h want %h", k, res, r[k]); end
      end
   endtask

   task automatic test_fairness;
      logic [3:0] vld; logic [31:0] res, opa, opb; logic tmo; int cyc, en;
      logic [3:0] exp [4];
      exp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
      set_ops(0, 32'h3F800000, 32'h3F800000);
      set_ops(3, 32'h40800000, 32'h40800000);
      bus.req = 4'b1001;
      for (int n = 0; n < 4; n++) begin
         serve(1, 32'h5A5A0000 | n, vld, res, tmo, opa, opb, cyc, en);
         checks++; if (vld !== exp[n]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", n, vld, exp[n]); end
         if (n < 3) bus.req[0] = 1'b1;
         if (n == 1) bus.req[3] = 1'b1;
      end
      bus.req = 4'b0;
   endtask

   task automatic test_timeout;
      logic [3:0] vld; logic [31:0] res, opa, opb; logic tmo; int cyc, en, n;
      set_ops(1, 32'h7F000000, 32'h7F000000);
      bus.req = 4'b0010;
      n = 0;
      while (!bus.unit_enable && n < 50) begin tick; n++; end
      tick;
      n = 0;
      while (bus.resp_valid === 4'b0 && n < 200) begin tick; n++; end
      checks++; if (n !== 64) begin errors++; $display("FAIL timeout_cycles: got %0d want 64", n); end
      checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL timeout_vld: got %b want 0010", bus.resp_valid); end
      checks++; if (bus.resp_result !== 32'h7FC00000) begin errors++; $display("FAIL timeout_result: got %h want 7fc00000", bus.resp_result); end
      checks++; if (bus.resp_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", bus.resp_timeout); end
      bus.req = 4'b0;
      tick;
      tick;
      bus.unit_done   = 1'b1;
      bus.unit_result = 32'h12345678;
      tick;
      bus.unit_done = 1'b0;
      tick;
      checks++; if (bus.resp_valid !== 4'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL late_done: vld=%b busy=%b want 0000/0", bus.resp_valid, bus.busy);
      end
      checks++; if (bus.resp_result !== 32'h7FC00000) begin errors++; $display("FAIL late_done_result: got %h want 7fc00000", bus.resp_result); end
      // Done on the last WAIT cycle beats the abort.
      bus.req = 4'b0010;
      serve(64, 32'h3E800000, vld, res, tmo, opa, opb, cyc, en);
      checks++; if (vld !== 4'b0010 || tmo !== 1'b0) begin errors++; $display("FAIL done_wins: vld=%b tmo=%b want 0010/0", vld, tmo); end
      checks++; if (res !== 32'h3E800000) begin errors++; $display("FAIL done_wins_result: got %h want 3e800000", res); end
   endtask

   task automatic test_zero_latency;
      logic [3:0] vld; logic [31:0] res, opa, opb; logic tmo; int cyc, en;
      tick;
      set_ops(3, 32'h40A00000, 32'h3F800000);
      bus.req = 4'b1000;
      serve(0, 32'h40A00000, vld, res, tmo, opa, opb, cyc, en);
      checks++; if (vld !== 4'b1000) begin errors++; $display("FAIL zero_vld: got %b want 1000", vld); end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", cyc); end
      checks++; if (res !== 32'h40A00000 || tmo !== 1'b0) begin errors++; $display("FAIL zero_result: got %h/%b want 40a00000/0", res, tmo); end
      checks++; if (en !== 1) begin errors++; $display("FAIL zero_enable: got %0d want 1", en); end
   endtask

   task automatic test_hold_disable;
      int n, en;
      bus0.req_dataa[63:32] = 32'h40400000;
      bus0.req_datab[63:32] = 32'h40400000;
      bus0.req = 4'b0010;
      n = 0;
      while (!bus0.unit_enable && n < 50) begin tick; n++; end
      en = int'(bus0.unit_enable);
      repeat (3) begin tick; en += int'(bus0.unit_enable); end
      bus0.unit_done   = 1'b1;
      bus0.unit_result = 32'h41100000;
      tick;
      bus0.unit_done = 1'b0;
      en += int'(bus0.unit_enable);
      checks++; if (en !== 1) begin errors++; $display("FAIL pulse_enable_cycles: got %0d want 1", en); end
      checks++; if (bus0.resp_valid !== 4'b0010 || bus0.resp_result !== 32'h41100000) begin
         errors++; $display("FAIL pulse_resp: vld=%b res=%h want 0010/41100000", bus0.resp_valid, bus0.resp_result);
      end
      bus0.req = 4'b0;
   endtask

   task automatic test_reset_mid;
      logic [3:0] vld; logic [31:0] res, opa, opb; logic tmo; int cyc, en, n, seen;
      tick;
      set_ops(0, 32'h3F000000, 32'h3F000000);
      set_ops(1, 32'h40E00000, 32'h40E00000);
      set_ops(2, 32'h41200000, 32'h41200000);
      bus.req = 4'b0010;
      serve(1, 32'h11111111, vld, res, tmo, opa, opb, cyc, en);
      checks++; if (vld !== 4'b0010) begin errors++; $display("FAIL mid_pre_vld: got %b want 0010", vld); end
      bus.req = 4'b0100;
      n = 0;
      while (!bus.unit_enable && n < 50) begin tick; n++; end
      tick;
      tick;
      reset_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.unit_enable !== 1'b0) begin
         errors++; $display("FAIL mid_reset_ctrl: busy=%b en=%b want 0/0", bus.busy, bus.unit_enable);
      end
      checks++; if (bus.unit_dataa !== 32'h0 || bus.resp_result !== 32'h0) begin
         errors++; $display("FAIL mid_reset_data: opa=%h res=%h want 0/0", bus.unit_dataa, bus.resp_result);
      end
      seen = 0;
      repeat (3) begin tick; if (bus.resp_valid !== 4'b0) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_resp: got %0d pulses want 0", seen); end
      reset_n = 1'b1;
      bus.req = 4'b0101;
      serve(2, 32'h22222222, vld, res, tmo, opa, opb, cyc, en);
      bus.req = 4'b0;
      checks++; if (vld !== 4'b0001) begin errors++; $display("FAIL mid_after_grant: got %b want 0001", vld); end
      checks++; if (opa !== 32'h3F000000 || res !== 32'h22222222) begin
         errors++; $display("FAIL mid_after_data: opa=%h res=%h want 3f000000/22222222", opa, res);
      end
   endtask

   initial begin
      bus.req = '0; bus.req_dataa = '0; bus.req_datab = '0;
      bus.unit_result = '0; bus.unit_done = 1'b0;
      bus0.req = '0; bus0.req_dataa = '0; bus0.req_datab = '0;
      bus0.unit_result = '0; bus0.unit_done = 1'b0;
      test_reset;
      test_single;
      test_all_four;
      test_fairness;
      test_timeout;
      test_zero_latency;
      test_hold_disable;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
